// File: rtl/gx4000_cpr_loader_if.sv
// Download-side bundle for the GX4000 CPR loader: HPS ioctl byte stream in,
// cartridge write port and load status out.
interface gx4000_cpr_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        cart_download;
  logic [24:0] cart_addr;
  logic [7:0]  cart_data;
  logic        cart_wr;
  logic        load_done;
  logic [1:0]  load_error;
  logic [15:0] cart_sum;

  modport master (
    input  ioctl_download, ioctl_wr, ioctl_dout,
    output cart_download, cart_addr, cart_data, cart_wr,
    output load_done, load_error, cart_sum
  );

  modport slave (
    output ioctl_download, ioctl_wr, ioctl_dout,
    input  cart_download, cart_addr, cart_data, cart_wr,
    input  load_done, load_error, cart_sum
  );
endinterface

// File: rtl/gx4000_cpr_loader.sv
// Amstrad CPR (RIFF "AMS!") parser feeding 16KB cartridge banks from the ioctl stream.
// Optional CART_CHECKSUM_EN adds a 16-bit wrapping sum of all written payload bytes.
module gx4000_cpr_loader #(
  parameter int MAX_BANKS  = 32,
  parameter int BANK_BYTES = 16384
) (
  input logic                 clk_sys,
  input logic                 reset,
  gx4000_cpr_loader_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_CHK_ID,
    S_CHK_SIZE,
    S_DATA,
    S_SKIP,
    S_PAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] size_reg, size_next;
  logic [4:0]  bank_reg, bank_next;
  logic [3:0]  digit_reg, digit_next;
  logic        skip_reg, skip_next;
  logic        dl_reg;
  logic        wr_reg, wr_next;
  logic [24:0] addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic        done_reg, done_next;
  logic [1:0]  err_reg, err_next;

  logic        rise;
  logic        fall;
  logic [7:0]  din;
  logic [31:0] cnt_inc;
  logic [31:0] size_full;
  logic [6:0]  bank_full;

  function automatic logic [7:0] hdr_char(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_char = 8'h52; // R
      4'd1:    hdr_char = 8'h49; // I
      4'd2:    hdr_char = 8'h46; // F
      4'd3:    hdr_char = 8'h46; // F
      4'd8:    hdr_char = 8'h41; // A
      4'd9:    hdr_char = 8'h4D; // M
      4'd10:   hdr_char = 8'h53; // S
      4'd11:   hdr_char = 8'h21; // !
      default: hdr_char = 8'h00;
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    is_digit = (b >= 8'h30) && (b <= 8'h39);
  endfunction

  assign rise      = bus.ioctl_download & ~dl_reg;
  assign fall      = ~bus.ioctl_download & dl_reg;
  assign din       = bus.ioctl_dout;
  assign cnt_inc   = cnt_reg + 32'd1;
  assign size_full = {din, size_reg[23:0]};
  // ASCII digits 0x30..0x39 carry their value in the low nibble.
  assign bank_full = ({3'b000, digit_reg} * 7'd10) + {3'b000, din[3:0]};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      size_reg  <= '0;
      bank_reg  <= '0;
      digit_reg <= '0;
      skip_reg  <= 1'b0;
      dl_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      size_reg  <= size_next;
      bank_reg  <= bank_next;
      digit_reg <= digit_next;
      skip_reg  <= skip_next;
      dl_reg    <= bus.ioctl_download;
      wr_reg    <= wr_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    size_next  = size_reg;
    bank_next  = bank_reg;
    digit_next = digit_reg;
    skip_next  = skip_reg;
    wr_next    = 1'b0;
    addr_next  = addr_reg;
    data_next  = data_reg;
    done_next  = done_reg;
    err_next   = err_reg;

    if (rise) begin
      state_next = S_HDR;
      cnt_next   = '0;
      skip_next  = 1'b0;
      done_next  = 1'b0;
      err_next   = '0;
    end else begin
      if (bus.ioctl_wr) begin
        case (state_reg)
          S_HDR: begin
            if ((cnt_reg[3:0] < 4'd4 || cnt_reg[3:0] >= 4'd8) &&
                din != hdr_char(cnt_reg[3:0])) begin
              state_next = S_ERR;
              err_next   = 2'd1;
            end else if (cnt_reg[3:0] == 4'd11) begin
              state_next = S_CHK_ID;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_inc;
            end
          end
          S_CHK_ID: begin
            case (cnt_reg[1:0])
              2'd0: begin
                skip_next = (din != 8'h63);
                cnt_next  = cnt_inc;
              end
              2'd1: begin
                if (din != 8'h62) skip_next = 1'b1;
                cnt_next = cnt_inc;
              end
              2'd2: begin
                if (!skip_reg && !is_digit(din)) begin
                  state_next = S_ERR;
                  err_next   = 2'd2;
                end else begin
                  digit_next = din[3:0];
                  cnt_next   = cnt_inc;
                end
              end
              default: begin
                if (!skip_reg &&
                    (!is_digit(din) || int'({25'd0, bank_full}) >= MAX_BANKS)) begin
                  state_next = S_ERR;
                  err_next   = 2'd2;
                end else begin
                  if (!skip_reg) bank_next = bank_full[4:0];
                  state_next = S_CHK_SIZE;
                  cnt_next   = '0;
                end
              end
            endcase
          end
          S_CHK_SIZE: begin
            size_next[{cnt_reg[1:0], 3'b000} +: 8] = din;
            if (cnt_reg[1:0] == 2'd3) begin
              cnt_next = '0;
              if (size_full == 32'd0)
                state_next = S_CHK_ID;
              else
                state_next = skip_reg ? S_SKIP : S_DATA;
            end else begin
              cnt_next = cnt_inc;
            end
          end
          S_DATA, S_SKIP: begin
            // Payload beyond one bank is consumed but never written.
            if (state_reg == S_DATA && cnt_reg < 32'(BANK_BYTES)) begin
              wr_next   = 1'b1;
              addr_next = {6'b000000, bank_reg, cnt_reg[13:0]};
              data_next = din;
            end
            if (cnt_inc == size_reg) begin
              cnt_next   = '0;
              state_next = size_reg[0] ? S_PAD : S_CHK_ID;
            end else begin
              cnt_next = cnt_inc;
            end
          end
          S_PAD: begin
            state_next = S_CHK_ID;
            cnt_next   = '0;
          end
          default: ;
        endcase
      end

      // The end of the transfer is judged on the state after any concurrent byte.
      if (fall) begin
        case (state_next)
          S_CHK_ID: begin
            if (cnt_next == 32'd0) begin
              state_next = S_DONE;
              done_next  = 1'b1;
            end else begin
              state_next = S_ERR;
              err_next   = 2'd3;
            end
          end
          S_HDR, S_CHK_SIZE, S_DATA, S_SKIP, S_PAD: begin
            state_next = S_ERR;
            err_next   = 2'd3;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CART_CHECKSUM_EN
  logic [15:0] sum_reg, sum_next;

  always_comb begin
    sum_next = sum_reg;
    if (rise)
      sum_next = '0;
    else if (wr_next)
      sum_next = sum_reg + {8'h00, data_next};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      sum_reg <= '0;
    else
      sum_reg <= sum_next;
  end

  assign bus.cart_sum = sum_reg;
`else
  assign bus.cart_sum = 16'h0000;
`endif

  assign bus.cart_download = dl_reg;
  assign bus.cart_wr       = wr_reg;
  assign bus.cart_addr     = addr_reg;
  assign bus.cart_data     = data_reg;
  assign bus.load_done     = done_reg;
  assign bus.load_error    = err_reg;

endmodule

// File: tb/tb_gx4000_cpr_loader.sv
// Bench for gx4000_cpr_loader: directed vector table, hand-written corner sequences,
// and random CPR images checked against a byte-level parse model.
module tb_gx4000_cpr_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gx4000_cpr_loader_if bus();

  gx4000_cpr_loader dut (
    .clk_sys(clk),
    .reset  (rst),
    .bus    (bus.master)
  );

  int errors = 0;
  int checks = 0;

  logic [24:0] got_addr[$];
  logic [7:0]  got_data[$];
  logic [24:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic        exp_done;
  logic [1:0]  exp_err;
  logic [7:0]  img_q[$];
  logic [7:0]  hdr_ref[12];

`ifdef CART_CHECKSUM_EN
  localparam logic [15:0] FF4_SUM = 16'h03FC;
  localparam bit SUM_ON = 1'b1;
`else
  localparam logic [15:0] FF4_SUM = 16'h0000;
  localparam bit SUM_ON = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        hdr_bad;
    logic [31:0] id;
    int          size;
    logic [7:0]  base;
    logic [7:0]  step;
    int          keep;
    int          exp_nwr;
    logic [24:0] exp_first;
    logic [24:0] exp_last;
    logic [7:0]  exp_last_data;
    logic        exp_done;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input string name, input logic hdr_bad, input logic [31:0] id,
                              input int size, input logic [7:0] base, input logic [7:0] step,
                              input int keep, input int nwr, input logic [24:0] first,
                              input logic [24:0] last, input logic [7:0] last_data,
                              input logic done, input logic [1:0] err);
    vec_t v;
    v.name = name; v.hdr_bad = hdr_bad; v.id = id; v.size = size; v.base = base;
    v.step = step; v.keep = keep; v.exp_nwr = nwr; v.exp_first = first;
    v.exp_last = last; v.exp_last_data = last_data; v.exp_done = done; v.exp_err = err;
    return v;
  endfunction

  always @(negedge clk) begin
    if (bus.cart_wr === 1'b1) begin
      got_addr.push_back(bus.cart_addr);
      got_data.push_back(bus.cart_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit drop);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_dout = b;
    if (drop) bus.ioctl_download = 1'b0;
    tick();
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic run_image(input int max_gap, input bit drop_last);
    got_addr.delete();
    got_data.delete();
    bus.ioctl_download = 1'b1;
    repeat (2) tick();
    foreach (img_q[i]) begin
      repeat ($urandom_range(max_gap)) tick();
      send_byte(img_q[i], drop_last && (i == img_q.size() - 1));
    end
    bus.ioctl_download = 1'b0;
    repeat (3) tick();
  endtask

  task automatic push_hdr();
    img_q.delete();
    for (int i = 0; i < 12; i++)
      img_q.push_back((i >= 4 && i < 8) ? 8'($urandom) : hdr_ref[i]);
  endtask

  task automatic push_chunk(input logic [31:0] id, input int size, input logic [7:0] base,
                            input logic [7:0] step);
    logic [31:0] s;
    s = 32'(size);
    for (int i = 3; i >= 0; i--) img_q.push_back(id[8*i +: 8]);
    for (int i = 0; i < 4; i++) img_q.push_back(s[8*i +: 8]);
    for (int k = 0; k < size; k++) img_q.push_back(base + 8'(k) * step);
    if (s[0]) img_q.push_back(8'h00);
  endtask

  // Reference parse: walks the whole image as an array and derives the writes and final status.
  task automatic model();
    int len, pos, avail, s, bank;
    bit cb;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 2'd0;
    len = img_q.size();
    for (int i = 0; i < 12; i++) begin
      if (i >= len) begin exp_err = 2'd3; return; end
      if ((i < 4 || i >= 8) && img_q[i] != hdr_ref[i]) begin exp_err = 2'd1; return; end
    end
    pos = 12;
    forever begin
      if (pos == len) begin exp_done = 1'b1; return; end
      avail = len - pos;
      cb = (avail >= 2) && img_q[pos] == 8'h63 && img_q[pos+1] == 8'h62;
      if (cb) begin
        for (int j = 2; j < 4; j++)
          if (j < avail && !(img_q[pos+j] >= 8'h30 && img_q[pos+j] <= 8'h39)) begin
            exp_err = 2'd2; return;
          end
        if (avail >= 4) begin
          bank = (int'(img_q[pos+2]) - 48) * 10 + (int'(img_q[pos+3]) - 48);
          if (bank >= 32) begin exp_err = 2'd2; return; end
        end
      end
      if (avail < 4) begin exp_err = 2'd3; return; end
      pos += 4;
      if (len - pos < 4) begin exp_err = 2'd3; return; end
      s = int'({img_q[pos+3], img_q[pos+2], img_q[pos+1], img_q[pos]});
      pos += 4;
      if (cb)
        for (int k = 0; k < s && k < 16384 && pos + k < len; k++) begin
          exp_addr.push_back(25'(bank * 16384 + k));
          exp_data.push_back(img_q[pos+k]);
        end
      if (pos + s + (s % 2) > len) begin exp_err = 2'd3; return; end
      pos += s + (s % 2);
    end
  endtask

  task automatic build_random();
    int n, kind, s, bank, cut;
    push_hdr();
    if ($urandom_range(9) == 0) img_q[$urandom_range(11)] ^= 8'h01;
    n = $urandom_range(3, 1);
    repeat (n) begin
      kind = $urandom_range(9);
      if (kind <= 5) begin
        bank = $urandom_range(34);
        img_q.push_back(8'h63); img_q.push_back(8'h62);
        img_q.push_back(8'(48 + bank / 10)); img_q.push_back(8'(48 + bank % 10));
      end else if (kind <= 7) begin
        img_q.push_back(8'h66); img_q.push_back(8'h6D);
        img_q.push_back(8'h74); img_q.push_back(8'h20);
      end else if (kind == 8) begin
        img_q.push_back(8'h63); img_q.push_back(8'h62);
        img_q.push_back(8'h3A); img_q.push_back(8'h30);
      end else begin
        img_q.push_back(8'h63); img_q.push_back(8'h42);
        img_q.push_back(8'($urandom)); img_q.push_back(8'($urandom));
      end
      s = $urandom_range(9);
      for (int i = 0; i < 4; i++) img_q.push_back(i == 0 ? 8'(s) : 8'h00);
      for (int k = 0; k < s; k++) img_q.push_back(8'($urandom));
      if (s % 2 == 1) img_q.push_back(8'($urandom));
    end
    if ($urandom_range(4) == 0) begin
      cut = $urandom_range(img_q.size() - 1);
      while (img_q.size() > cut) void'(img_q.pop_back());
    end
  endtask

  initial begin
    logic [15:0] sum;
    int n;
    hdr_ref = '{8'h52, 8'h49, 8'h46, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h41, 8'h4D, 8'h53, 8'h21};

    vecs[0] = mk("cb00_s4",   0, "cb00", 4,     8'd11,  8'd11, 0,  4,     25'h0,     25'h3,     8'd44,  1, 0);
    vecs[1] = mk("cb31_s2",   0, "cb31", 2,     8'h10,  8'h01, 0,  2,     25'h7C000, 25'h7C001, 8'h11,  1, 0);
    vecs[2] = mk("cb31_s3",   0, "cb31", 3,     8'h01,  8'h01, 0,  3,     25'h7C000, 25'h7C002, 8'h03,  1, 0);
    vecs[3] = mk("cb32_bad",  0, "cb32", 2,     8'h01,  8'h01, 0,  0,     25'h0,     25'h0,     8'h00,  0, 2);
    vecs[4] = mk("cbx1_bad",  0, "cbx1", 2,     8'h01,  8'h01, 0,  0,     25'h0,     25'h0,     8'h00,  0, 2);
    vecs[5] = mk("fmt_skip",  0, "fmt ", 6,     8'h01,  8'h01, 0,  0,     25'h0,     25'h0,     8'h00,  1, 0);
    vecs[6] = mk("trunc_dat", 0, "cb05", 4,     8'hA0,  8'h01, 22, 2,     25'h14000, 25'h14001, 8'hA1,  0, 3);
    vecs[7] = mk("riff_bad",  1, "cb00", 4,     8'h01,  8'h01, 0,  0,     25'h0,     25'h0,     8'h00,  0, 1);
    vecs[8] = mk("trunc_hdr", 0, "cb00", 4,     8'h01,  8'h01, 6,  0,     25'h0,     25'h0,     8'h00,  0, 3);
    vecs[9] = mk("big_chunk", 0, "cb00", 16386, 8'hFF,  8'h00, 0,  16384, 25'h0,     25'h3FFF,  8'hFF,  1, 0);

    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_dout     = 8'h00;
    repeat (3) tick();
    chk("reset cart_wr",       32'(bus.cart_wr), 32'd0);
    chk("reset cart_addr",     32'(bus.cart_addr), 32'd0);
    chk("reset status",        32'({bus.load_done, bus.load_error, bus.cart_download}), 32'd0);
    chk("reset cart_sum",      32'(bus.cart_sum), 32'd0);
    rst = 1'b0;
    tick();

    // cart_download is the download flag one clock later; an empty transfer is truncated
    bus.ioctl_download = 1'b1;
    #1;
    chk("dl delay before edge", 32'(bus.cart_download), 32'd0);
    tick();
    chk("dl delay after edge",  32'(bus.cart_download), 32'd1);
    bus.ioctl_download = 1'b0;
    repeat (2) tick();
    chk("empty dl error",       32'(bus.load_error), 32'd3);

    foreach (vecs[i]) begin
      push_hdr();
      if (vecs[i].hdr_bad) img_q[3] = 8'h58;
      push_chunk(vecs[i].id, vecs[i].size, vecs[i].base, vecs[i].step);
      if (vecs[i].keep > 0) while (img_q.size() > vecs[i].keep) void'(img_q.pop_back());
      run_image(0, 1'b0);
      chk({vecs[i].name, " nwr"}, 32'(got_addr.size()), 32'(vecs[i].exp_nwr));
      if (vecs[i].exp_nwr > 0 && got_addr.size() > 0) begin
        chk({vecs[i].name, " first addr"}, 32'(got_addr[0]), 32'(vecs[i].exp_first));
        chk({vecs[i].name, " last addr"},  32'(got_addr[$]), 32'(vecs[i].exp_last));
        chk({vecs[i].name, " last data"},  32'(got_data[$]), 32'(vecs[i].exp_last_data));
      end
      chk({vecs[i].name, " done"},  32'(bus.load_done),  32'(vecs[i].exp_done));
      chk({vecs[i].name, " error"}, 32'(bus.load_error), 32'(vecs[i].exp_err));
    end

    // odd chunk with pad byte followed by a second bank
    push_hdr();
    push_chunk("cb31", 3, 8'h01, 8'h01);
    push_chunk("cb01", 2, 8'h55, 8'h01);
    run_image(1, 1'b0);
    chk("pad seq nwr",      32'(got_addr.size()), 32'd5);
    if (got_addr.size() == 5) begin
      chk("pad seq addr3",  32'(got_addr[3]), 32'h04000);
      chk("pad seq data4",  32'(got_data[4]), 32'h56);
    end
    chk("pad seq done",     32'(bus.load_done), 32'd1);

    // write latency, held address and checksum
    push_hdr();
    push_chunk("cb00", 4, 8'hFF, 8'h00);
    got_addr.delete();
    got_data.delete();
    bus.ioctl_download = 1'b1;
    repeat (2) tick();
    foreach (img_q[i]) send_byte(img_q[i], 1'b0);
    chk("latency cart_wr",  32'(bus.cart_wr), 32'd1);
    chk("latency addr",     32'(bus.cart_addr), 32'h3);
    chk("ff4 cart_sum",     32'(bus.cart_sum), 32'(FF4_SUM));
    tick();
    chk("strobe one cycle", 32'(bus.cart_wr), 32'd0);
    chk("addr held",        32'(bus.cart_addr), 32'h3);
    bus.ioctl_download = 1'b0;
    repeat (2) tick();
    chk("ff4 done",         32'(bus.load_done), 32'd1);

    // last byte arrives in the same cycle the download flag drops
    push_hdr();
    push_chunk("cb02", 2, 8'h70, 8'h01);
    run_image(0, 1'b1);
    chk("drop_last nwr",    32'(got_addr.size()), 32'd2);
    chk("drop_last done",   32'(bus.load_done), 32'd1);
    chk("drop_last error",  32'(bus.load_error), 32'd0);

    // reset in the middle of a DATA chunk
    push_hdr();
    push_chunk("cb00", 8, 8'h00, 8'h00);
    got_addr.delete();
    got_data.delete();
    bus.ioctl_download = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 23; i++) send_byte(img_q[i], 1'b0);
    chk("pre-reset nwr",    32'(got_addr.size()), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid reset outputs", 32'({bus.cart_wr, bus.cart_addr, bus.cart_download, bus.load_done}), 32'd0);
    tick();
    rst = 1'b0;
    got_addr.delete();
    for (int i = 23; i < img_q.size(); i++) send_byte(img_q[i], 1'b0);
    bus.ioctl_download = 1'b0;
    repeat (3) tick();
    chk("post-reset nwr",   32'(got_addr.size()), 32'd0);

    // random images against the reference parse
    for (int t = 0; t < 40; t++) begin
      build_random();
      model();
      run_image(2, 1'b0);
      chk($sformatf("rnd%0d nwr", t), 32'(got_addr.size()), 32'(exp_addr.size()));
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      sum = 16'h0000;
      foreach (exp_data[k]) sum += {8'h00, exp_data[k]};
      for (int k = 0; k < n; k++) begin
        chk($sformatf("rnd%0d addr%0d", t, k), 32'(got_addr[k]), 32'(exp_addr[k]));
        chk($sformatf("rnd%0d data%0d", t, k), 32'(got_data[k]), 32'(exp_data[k]));
      end
      chk($sformatf("rnd%0d done", t),  32'(bus.load_done),  32'(exp_done));
      chk($sformatf("rnd%0d error", t), 32'(bus.load_error), 32'(exp_err));
      chk($sformatf("rnd%0d sum", t),   32'(bus.cart_sum),   SUM_ON ? 32'(sum) : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
